approx_err_monitor: RTL and testbench

Synthesizable on-chip error-metric accumulator for approximate multipliers. It streams paired exact/approximate products of parametrised width through a valid/ready handshake and keeps running statistics over a programmed sample count: error count, signed error sum, absolute error sum, maximum absolute error, and count of exact-zero samples. Host logic or software derives ER, MED and MNED from these results. It sits between a stimulus generator, the exact and approximate multiplier instances, and a register/readout interface.

---
 rtl/approx_err_monitor.sv | 154 +++++++++++++++
 tb/tb_approx_err_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_monitor.sv
// Streams exact/approximate product pairs and accumulates error statistics
// (counts, signed/absolute error sums, max error) over a programmed run.
module approx_err_monitor #(
    parameter int W     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48    // must be >= W+2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     exact,
    input  logic [W-1:0]     apprx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] zero_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [ACC_W-1:0] sum_ed_abs,
    output logic [W-1:0]     max_ed,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             drain_cnt;
    logic [CNT_W-1:0] target;

    logic             s1_valid;
    logic [W:0]       s1_diff;
    logic [W-1:0]     s1_absd;
    logic             s1_neq;
    logic             s1_zero;

    logic             xfer;
    logic             start_ok;
    logic [CNT_W-1:0] count_inc;
    logic [W:0]       diff;
    logic [W:0]       neg_diff;
    logic [W-1:0]     absd;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W:0]   abs_wide;
    logic [ACC_W-1:0] sum_sat;
    logic [ACC_W-1:0] abs_sat;
    logic             sum_clip;
    logic             abs_clip;

    assign in_ready  = (state == S_RUN);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign count_inc = sample_count + CNT_W'(1);

    // W+1-bit difference of zero-extended operands; magnitude always fits in W bits
    assign diff     = {1'b0, exact} - {1'b0, apprx};
    assign neg_diff = -diff;
    assign absd     = diff[W] ? neg_diff[W-1:0] : diff[W-1:0];

    // One guard bit above each accumulator detects the clamp condition
    assign sum_wide = {sum_ed[ACC_W-1], sum_ed} + {{(ACC_W-W){s1_diff[W]}}, s1_diff};
    assign sum_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_sat  = !sum_clip      ? sum_wide[ACC_W-1:0] :
                      sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
    assign abs_wide = {1'b0, sum_ed_abs} + {{(ACC_W+1-W){1'b0}}, s1_absd};
    assign abs_clip = abs_wide[ACC_W];
    assign abs_sat  = abs_clip ? {ACC_W{1'b1}} : abs_wide[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            drain_cnt    <= 1'b0;
            target       <= '0;
            sample_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state        <= S_RUN;
                        target       <= (n_samples == '0) ? CNT_W'(1) : n_samples;
                        sample_count <= '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        sample_count <= count_inc;
                        if (count_inc == target) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two drain cycles let the last sample retire through stage 2
                    if (drain_cnt) state <= S_DONE;
                    else           drain_cnt <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_absd  <= '0;
            s1_neq   <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_diff <= diff;
                s1_absd <= absd;
                s1_neq  <= (exact != apprx);
                s1_zero <= (exact == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            zero_count <= '0;
            sum_ed     <= '0;
            sum_ed_abs <= '0;
            max_ed     <= '0;
            ovf        <= 1'b0;
        end else if (start_ok) begin
            err_count  <= '0;
            zero_count <= '0;
            sum_ed     <= '0;
            sum_ed_abs <= '0;
            max_ed     <= '0;
            ovf        <= 1'b0;
        end else if (s1_valid) begin
            err_count  <= err_count + CNT_W'(s1_neq);
            zero_count <= zero_count + CNT_W'(s1_zero);
            sum_ed     <= sum_sat;
            sum_ed_abs <= abs_sat;
            if (s1_absd > max_ed) max_ed <= s1_absd;
            ovf        <= ovf | sum_clip | abs_clip;
        end
    end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomized scoreboard bench: two instances (wide and narrow accumulators)
// share stimulus; a reference model predicts results checked when done rises.
module tb_approx_err_monitor;

    localparam int W     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;
    localparam int ACC_S = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     exact = '0;
    logic [W-1:0]     apprx = '0;

    logic             in_ready, busy, done, ovf;
    logic [CNT_W-1:0] sample_count, err_count, zero_count;
    logic [ACC_W-1:0] sum_ed, sum_ed_abs;
    logic [W-1:0]     max_ed;

    logic             s_in_ready, s_busy, s_done, s_ovf;
    logic [CNT_W-1:0] s_sample_count, s_err_count, s_zero_count;
    logic [ACC_S-1:0] s_sum_ed, s_sum_ed_abs;
    logic [W-1:0]     s_max_ed;

    approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .apprx(apprx),
        .busy(busy), .done(done), .sample_count(sample_count),
        .err_count(err_count), .zero_count(zero_count), .sum_ed(sum_ed),
        .sum_ed_abs(sum_ed_abs), .max_ed(max_ed), .ovf(ovf)
    );

    approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .exact(exact), .apprx(apprx),
        .busy(s_busy), .done(s_done), .sample_count(s_sample_count),
        .err_count(s_err_count), .zero_count(s_zero_count), .sum_ed(s_sum_ed),
        .sum_ed_abs(s_sum_ed_abs), .max_ed(s_max_ed), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint sc; longint ec; longint zc;
        longint se; longint sa; longint mx;
        longint ov; longint done_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t ea, es;
    int   acc_ex[$], acc_ap[$];
    int   st_ex[$], st_ap[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_q = 1'b0, s_done_q = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: apply each accepted pair in order with saturating sums
    function automatic exp_t model(input int acc_w, input longint dc);
        exp_t   r;
        longint smax, smin, amax, d, ad;
        smax = (longint'(1) <<< (acc_w - 1)) - 1;
        smin = -smax - 1;
        amax = (longint'(1) <<< acc_w) - 1;
        r = '{default: 0};
        r.done_cyc = dc;
        r.sc = acc_ex.size();
        foreach (acc_ex[i]) begin
            d  = longint'(acc_ex[i]) - longint'(acc_ap[i]);
            ad = (d < 0) ? -d : d;
            if (d != 0) r.ec += 1;
            if (acc_ex[i] == 0) r.zc += 1;
            r.se += d;
            if (r.se > smax) begin r.se = smax; r.ov = 1; end
            else if (r.se < smin) begin r.se = smin; r.ov = 1; end
            r.sa += ad;
            if (r.sa > amax) begin r.sa = amax; r.ov = 1; end
            if (ad > r.mx) r.mx = ad;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                ea = q_a.pop_front();
                chk("a_sample_count", sample_count, ea.sc);
                chk("a_err_count", err_count, ea.ec);
                chk("a_zero_count", zero_count, ea.zc);
                chk("a_sum_ed", $signed(sum_ed), ea.se);
                chk("a_sum_ed_abs", sum_ed_abs, ea.sa);
                chk("a_max_ed", max_ed, ea.mx);
                chk("a_ovf", ovf, ea.ov);
                chk("a_done_cycle", cyc, ea.done_cyc);
                $display("run done (ACC_W=%0d): n=%0d err=%0d zero=%0d sum=%0d abs=%0d max=%0d ovf=%0d",
                         ACC_W, sample_count, err_count, zero_count, $signed(sum_ed),
                         sum_ed_abs, max_ed, ovf);
            end
        end
        done_q = done;
    end

    always @(negedge clk) begin
        if (s_done && !s_done_q) begin
            if (q_s.size() == 0) chk("s_unexpected_done", 1, 0);
            else begin
                es = q_s.pop_front();
                chk("s_sample_count", s_sample_count, es.sc);
                chk("s_err_count", s_err_count, es.ec);
                chk("s_zero_count", s_zero_count, es.zc);
                chk("s_sum_ed", $signed(s_sum_ed), es.se);
                chk("s_sum_ed_abs", s_sum_ed_abs, es.sa);
                chk("s_max_ed", s_max_ed, es.mx);
                chk("s_ovf", s_ovf, es.ov);
                chk("s_done_cycle", cyc, es.done_cyc);
                $display("run done (ACC_W=%0d): sum=%0d abs=%0d ovf=%0d",
                         ACC_S, $signed(s_sum_ed), s_sum_ed_abs, s_ovf);
            end
        end
        s_done_q = s_done;
    end

    task automatic gen_pair(output int e, output int a);
        int r;
        r = $urandom_range(99);
        e = $urandom_range(65535);
        a = $urandom_range(65535);
        if (r < 15)      a = e;
        else if (r < 25) e = 0;
        else if (r < 40) a = (e + $urandom_range(40)) & 16'hFFFF;
    endtask

    task automatic fill_rand(input int n);
        int e, a;
        st_ex.delete();
        st_ap.delete();
        repeat (n) begin
            gen_pair(e, a);
            st_ex.push_back(e);
            st_ap.push_back(a);
        end
    endtask

    task automatic idle_pulses();
        @(negedge clk);
        repeat (3) begin
            in_valid = 1'b1;
            exact = W'($urandom);
            apprx = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle_sample_count", sample_count, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_err_count", err_count, 0);
    endtask

    task automatic do_run(input int n, input int gap_pct);
        int eff, k, guard;
        bit xfer;
        eff = (n == 0) ? 1 : n;
        acc_ex.delete();
        acc_ap.delete();
        @(negedge clk);
        start = 1'b1;
        n_samples = CNT_W'(n);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("clr_sample_count", sample_count, 0);
        chk("clr_err_count", err_count, 0);
        chk("clr_sum_ed_abs", sum_ed_abs, 0);
        chk("clr_max_ed", max_ed, 0);
        chk("clr_s_sum_ed_abs", s_sum_ed_abs, 0);
        chk("clr_s_ovf", s_ovf, 0);
        chk("run_busy", busy, 1);
        chk("run_done_low", done, 0);
        k = 0;
        guard = 0;
        while (k < eff && guard < 1000) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                exact = W'($urandom);
                apprx = W'($urandom);
            end else begin
                in_valid = 1'b1;
                exact = W'(st_ex[k]);
                apprx = W'(st_ap[k]);
            end
            xfer = in_valid && in_ready;
            if (xfer) begin
                acc_ex.push_back(int'(exact));
                acc_ap.push_back(int'(apprx));
                k++;
                if (k == eff) begin
                    q_a.push_back(model(ACC_W, cyc + 3));
                    q_s.push_back(model(ACC_S, cyc + 3));
                end
            end
            @(negedge clk);
            guard++;
            if (xfer) chk("sample_count_inc", sample_count, k);
        end
        if (k < eff) chk("run_transfer_timeout", k, eff);
        // Extra valid pair offered after the final transfer must be refused
        in_valid = 1'b1;
        exact = W'($urandom);
        apprx = W'($urandom);
        chk("ready_drop", in_ready, 0);
        guard = 0;
        while (!done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("done_seen", done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        idle_pulses();

        st_ex = '{0, 100, 65535, 7};
        st_ap = '{0, 100, 65535, 7};
        do_run(4, 0);

        st_ex = '{1000, 50, 0};
        st_ap = '{990, 80, 0};
        do_run(3, 0);

        fill_rand(5);
        do_run(5, 40);

        st_ex.delete();
        st_ap.delete();
        repeat (8) begin
            st_ex.push_back(65535);
            st_ap.push_back(0);
        end
        do_run(8, 0);

        fill_rand(1);
        do_run(0, 0);

        repeat (6) begin
            int n;
            n = $urandom_range(1, 24);
            fill_rand(n);
            do_run(n, 25);
        end

        // Reset in the middle of a run
        fill_rand(10);
        @(negedge clk);
        start = 1'b1;
        n_samples = CNT_W'(10);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            exact = W'(st_ex[i]);
            apprx = W'(st_ap[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("midrun_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sample_count", sample_count, 0);
        chk("arst_sum_ed_abs", sum_ed_abs, 0);
        chk("arst_max_ed", max_ed, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_s_sum_ed_abs", s_sum_ed_abs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_pulses();

        repeat (3) @(negedge clk);
        chk("a_queue_empty", q_a.size(), 0);
        chk("s_queue_empty", q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
